// File: rtl/mem_access_stage_pkg.sv
// Shared types and sizing for the memory-access pipeline stage.
package mem_access_stage_pkg;

    localparam int DEPTH   = 16;
    localparam int DW      = 32;
    localparam int RW_BITS = 4;
    localparam int FCW     = 8;

    // Instruction as it sits in the MA slot, straight from EX.
    typedef struct packed {
        logic               ld;
        logic               st;
        logic               wb;
        logic [RW_BITS-1:0] rd;
        logic [DW-1:0]      alu_result;
        logic [DW-1:0]      op2;
    } ma_slot_t;

    // Result as it sits in the RW slot, headed for register writeback.
    typedef struct packed {
        logic               is_ld;
        logic               is_wb;
        logic [RW_BITS-1:0] rd;
        logic [DW-1:0]      ld_result;
        logic [DW-1:0]      alu_result;
        logic               fault;
    } rw_slot_t;

    // Occupancy of the two slots, encoded as {ma_valid, rw_valid}.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        RW_ONLY = 2'b01,
        MA_ONLY = 2'b10,
        FULL    = 2'b11
    } occ_t;

    // True when a word address falls inside the data memory.
    function automatic logic addr_in_range(input logic [DW-1:0] addr);
        return addr < DW'(DEPTH);
    endfunction

endpackage

// File: rtl/mem_access_stage_slot.sv
// Single-entry valid/ready register slot. Accepts whenever it is empty or its
// current contents are leaving in the same cycle; data holds otherwise.
module pipe_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    // Load on an accepted handshake, drop valid when drained with nothing new.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: MA slot drives the data memory, RW slot holds
// the result for writeback. Illegal accesses are trapped and counted.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               ex_is_ld,
    input  logic               ex_is_st,
    input  logic               ex_is_wb,
    input  logic [RW_BITS-1:0] ex_rd,
    input  logic [DW-1:0]      ex_alu_result,
    input  logic [DW-1:0]      ex_op2,
    output logic               mem_isLd,
    output logic               mem_isSt,
    output logic [DW-1:0]      mem_address,
    output logic [DW-1:0]      mem_data_in,
    input  logic [DW-1:0]      mem_data_out,
    output logic               rw_valid,
    input  logic               rw_ready,
    output logic               rw_is_ld,
    output logic               rw_is_wb,
    output logic [RW_BITS-1:0] rw_rd,
    output logic [DW-1:0]      rw_ld_result,
    output logic [DW-1:0]      rw_alu_result,
    output logic               rw_fault,
    output logic [FCW-1:0]     fault_count
);

    ma_slot_t ex_in;
    ma_slot_t ma;
    rw_slot_t rw_next;
    rw_slot_t rw;
    logic     ma_valid;
    logic     rw_can_take;
    logic     ma_adv;
    logic     fault;
    occ_t     occ;

    assign ex_in = '{ld: ex_is_ld, st: ex_is_st, wb: ex_is_wb, rd: ex_rd,
                     alu_result: ex_alu_result, op2: ex_op2};

    pipe_slot #(.W($bits(ma_slot_t))) u_ma_slot (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (ex_valid),
        .in_ready  (ex_ready),
        .in_data   (ex_in),
        .out_valid (ma_valid),
        .out_ready (ma_adv),
        .out_data  (ma)
    );

    pipe_slot #(.W($bits(rw_slot_t))) u_rw_slot (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (ma_adv),
        .in_ready  (rw_can_take),
        .in_data   (rw_next),
        .out_valid (rw_valid),
        .out_ready (rw_ready),
        .out_data  (rw)
    );

    assign occ = occ_t'({ma_valid, rw_valid});

    // MA advances when it holds something and the RW slot is free or draining.
    always_comb begin
        ma_adv = 1'b0;
        unique case (occ)
            MA_ONLY: ma_adv = 1'b1;
            FULL:    ma_adv = rw_can_take;
            default: ma_adv = 1'b0;
        endcase
    end

    assign fault = ma_valid & (ma.ld | ma.st)
                 & (~addr_in_range(ma.alu_result) | (ma.ld & ma.st));

    // Stores fire only on the leaving edge so a stalled store writes once;
    // reset suppresses the write so a store caught in MA is dropped.
    assign mem_address = ma.alu_result;
    assign mem_data_in = ma.op2;
    assign mem_isLd    = ma_valid & ma.ld & ~fault;
    assign mem_isSt    = ma_adv & ma.st & ~fault & ~reset;

    // Build the writeback result; trapped accesses never write rd or load data.
    always_comb begin
        rw_next            = '0;
        rw_next.is_ld      = ma.ld;
        rw_next.is_wb      = ma.wb & ~fault;
        rw_next.rd         = ma.rd;
        rw_next.ld_result  = (ma.ld & ~fault) ? mem_data_out : '0;
        rw_next.alu_result = ma.alu_result;
        rw_next.fault      = fault;
    end

    assign rw_is_ld      = rw.is_ld;
    assign rw_is_wb      = rw.is_wb;
    assign rw_rd         = rw.rd;
    assign rw_ld_result  = rw.ld_result;
    assign rw_alu_result = rw.alu_result;
    assign rw_fault      = rw.fault;

    // Count trapped accesses as they leave MA, sticking at the maximum.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_count <= '0;
        end else if (ma_adv && fault && (fault_count != '1)) begin
            fault_count <= fault_count + 1'b1;
        end
    end

endmodule
